markov_table_arbiter: RTL and testbench

Arbitrates single-port access to the shared Markov transition-count memory between up to NUM_REQ requesters: the merge engine, the chain sampler and the host table loader. The arbiter grants one requester at a time, holds the grant for a locked burst up to a bounded length, and muxes that requester's command onto the memory port. It also routes read data back to the issuing requester. The block sits between the merge/sampling engines and the transition-table RAM, which has a 1-cycle read latency.

---
 rtl/markov_table_arbiter_pkg.sv | 22 ++
 rtl/markov_table_arbiter_if.sv | 35 +++
 rtl/markov_table_arbiter_rr_pick.sv | 36 +++
 rtl/markov_table_arbiter.sv | 138 +++++++++++++
 tb/tb_markov_table_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/markov_table_arbiter_pkg.sv
// Shared definitions for the Markov transition-table arbiter.
// Holds the arbiter state encoding, default table widths and requester indices.
package markov_pkg;

    localparam int unsigned TBL_ADDR_W = 10;
    localparam int unsigned TBL_DATA_W = 16;

    localparam int unsigned REQ_MERGE  = 0;
    localparam int unsigned REQ_SAMPLE = 1;
    localparam int unsigned REQ_HOST   = 2;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // Index width for a requester count, never below one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/markov_table_arbiter_if.sv
// Requester command bus plus memory port of the transition-table arbiter.
// slave: the arbiter; master: requesters and the table RAM around it.
interface markov_arb_if
    import markov_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = TBL_ADDR_W,
    parameter int unsigned DATA_W  = TBL_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, lock, req_addr, req_we, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, lock, req_addr, req_we, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/markov_table_arbiter_rr_pick.sv
// Combinational round-robin winner select; search starts one past rr_ptr.
// With prio_en, the merge engine wins outright whenever it requests.
module markov_rr_pick
    import markov_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               prio_en,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // First requester found after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        if (prio_en && req[IDX_W'(REQ_MERGE)]) begin
            winner[IDX_W'(REQ_MERGE)] = 1'b1;
            valid                     = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx = (32'(rr_ptr) + k) % NUM_REQ;
                if (!valid && req[IDX_W'(idx)]) begin
                    winner[IDX_W'(idx)] = 1'b1;
                    valid               = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/markov_table_arbiter.sv
// Single-port arbiter for the Markov transition-count RAM.
// Grants one requester at a time for a locked burst of up to MAX_BURST
// accesses, muxes its command onto the RAM port and steers read data back.
// Build option: define MARKOV_ARB_PRIORITY_EN to give the merge engine
// (requester 0) strict priority at each grant decision.
module markov_table_arbiter
    import markov_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = TBL_ADDR_W,
    parameter int unsigned DATA_W    = TBL_DATA_W,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic         clk,
    input  logic         reset,
    markov_arb_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

`ifdef MARKOV_ARB_PRIORITY_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   burst_cnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rvalid_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic               own_req;
    logic               own_lock;
    logic               own_we;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_wdata;
    logic               release_c;

    markov_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .prio_en (PRIO_EN),
        .winner  (pick_oh),
        .valid   (pick_valid)
    );

    // One-hot winner to index for the owner register
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

    // Owner's command slices; everything reads zero outside OWN
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state == ARB_OWN && owner == IDX_W'(i)) begin
                own_req   = bus.req[i];
                own_lock  = bus.lock[i];
                own_we    = bus.req_we[i];
                own_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
        release_c = (state == ARB_OWN) &&
                    (!own_req || !own_lock || (burst_cnt == LAST_BEAT));
    end

    // Owner's command goes straight to the RAM in the same cycle
    assign bus.mem_en    = own_req;
    assign bus.mem_we    = own_we;
    assign bus.mem_addr  = own_addr;
    assign bus.mem_wdata = own_wdata;
    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    // RAM output is already aligned with rvalid; zero it when not qualified
    assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : '0;

    // Grant FSM: pick in IDLE, count accesses in OWN, release to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            gnt_q     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state     <= ARB_OWN;
                        owner     <= pick_idx;
                        gnt_q     <= pick_oh;
                        burst_cnt <= '0;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ARB_OWN: begin
                    if (own_req) burst_cnt <= burst_cnt + CNT_W'(1);
                    if (release_c) begin
                        state  <= ARB_IDLE;
                        gnt_q  <= '0;
                        rr_ptr <= owner;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Read return flag: one cycle after a read access, to the issuing owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= (own_req && !own_we) ? gnt_q : '0;
        end
    end

endmodule

// File: tb/tb_markov_table_arbiter.sv
// Directed bench for markov_table_arbiter: vector tables for streaming
// patterns, hand-written sequences for bursts, reset and handoff corners.
module tb_markov_table_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

`ifdef MARKOV_ARB_PRIORITY_EN
    localparam logic [2:0] T4_C8 = 3'b001;
`else
    localparam logic [2:0] T4_C8 = 3'b100;
`endif

    typedef struct packed {
        logic [2:0]       req;
        logic [2:0]       lock;
        logic [2:0]       we;
        logic [2:0][9:0]  addr;
        logic [2:0]       e_gnt;
        logic             e_en;
        logic             e_we;
        logic [9:0]       e_addr;
        logic [2:0]       e_rv;
        logic [15:0]      e_rdata;
    } vec_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t vt[$];
    logic [15:0] ram [1024];

    markov_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    markov_table_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_val(input logic [9:0] a);
        return 16'hA000 ^ {6'd0, a};
    endfunction

    function automatic logic [15:0] wd(input int i, input logic [9:0] a);
        return {4'(i + 1), 2'b00, a};
    endfunction

    function automatic int oh2i(input logic [2:0] oh);
        for (int i = 0; i < 3; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // Table RAM model: synchronous read, data valid the cycle after access
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(10'(i));
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata   <= ram[bus.mem_addr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] we,
                         input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
        bus.req       = rq;
        bus.lock      = lk;
        bus.req_we    = we;
        bus.req_addr  = {a2, a1, a0};
        bus.req_wdata = {wd(2, a2), wd(1, a1), wd(0, a0)};
    endtask

    function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] we,
                                input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                                input logic [2:0] eg, input logic ee, input logic ewe,
                                input logic [9:0] ea, input logic [2:0] erv, input logic [15:0] erd);
        vec_t v;
        v.req = rq; v.lock = lk; v.we = we;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
        v.e_gnt = eg; v.e_en = ee; v.e_we = ewe; v.e_addr = ea;
        v.e_rv = erv; v.e_rdata = erd;
        return v;
    endfunction

    task automatic run_vecs(input string tag);
        foreach (vt[r]) begin
            nxt();
            drive(vt[r].req, vt[r].lock, vt[r].we, vt[r].addr[0], vt[r].addr[1], vt[r].addr[2]);
            @(negedge clk);
            chk($sformatf("%s[%0d] gnt", tag, r),      32'(bus.gnt),      32'(vt[r].e_gnt));
            chk($sformatf("%s[%0d] mem_en", tag, r),   32'(bus.mem_en),   32'(vt[r].e_en));
            chk($sformatf("%s[%0d] mem_we", tag, r),   32'(bus.mem_we),   32'(vt[r].e_we));
            chk($sformatf("%s[%0d] mem_addr", tag, r), 32'(bus.mem_addr), 32'(vt[r].e_addr));
            chk($sformatf("%s[%0d] rvalid", tag, r),   32'(bus.rvalid),   32'(vt[r].e_rv));
            chk($sformatf("%s[%0d] rdata", tag, r),    32'(bus.rdata),    32'(vt[r].e_rdata));
            if (vt[r].e_we)
                chk($sformatf("%s[%0d] mem_wdata", tag, r), 32'(bus.mem_wdata),
                    32'(wd(oh2i(vt[r].e_gnt), vt[r].e_addr)));
        end
    endtask

    initial begin
        int k2;
        bit done0;
        logic [2:0] t3_exp [17];
        logic [2:0] t4_req [10];
        logic [2:0] t4_lock [10];
        logic [2:0] t4_exp [10];

        t3_exp  = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                    3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        t4_req  = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
        t4_lock = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        t4_exp  = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b010, 3'b000, T4_C8, 3'b000};

        // Reset values
        reset = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        repeat (3) @(negedge clk);
        chk("rst gnt",       32'(bus.gnt),       32'h0);
        chk("rst rvalid",    32'(bus.rvalid),    32'h0);
        chk("rst rdata",     32'(bus.rdata),     32'h0);
        chk("rst mem_en",    32'(bus.mem_en),    32'h0);
        chk("rst mem_we",    32'(bus.mem_we),    32'h0);
        chk("rst mem_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst mem_wdata", 32'(bus.mem_wdata), 32'h0);
        reset = 1'b1;

        // All three requesters, single unlocked writes: 0,1,2,0 with IDLE gaps
        vt = {};
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h300, 10'h310, 10'h320, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h300, 10'h310, 10'h320, 3'b001, 1, 1, 10'h300, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h301, 10'h310, 10'h320, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h301, 10'h310, 10'h320, 3'b010, 1, 1, 10'h310, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h301, 10'h311, 10'h320, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h301, 10'h311, 10'h320, 3'b100, 1, 1, 10'h320, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h301, 10'h311, 10'h321, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        vt.push_back(mk(3'b111, 3'b000, 3'b111, 10'h301, 10'h311, 10'h321, 3'b001, 1, 1, 10'h301, 3'b000, 16'h0));
        vt.push_back(mk(3'b000, 3'b000, 3'b000, 10'h000, 10'h000, 10'h000, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        run_vecs("rr");
        chk("ram 300", 32'(ram[10'h300]), 32'h1300);
        chk("ram 310", 32'(ram[10'h310]), 32'h2310);
        chk("ram 320", 32'(ram[10'h320]), 32'h3320);
        chk("ram 301", 32'(ram[10'h301]), 32'h1301);
        chk("ram 311", 32'(ram[10'h311]), 32'hA311);

        // Requester 1 alone: locked read burst of four, reads return next cycle
        vt = {};
        vt.push_back(mk(3'b010, 3'b010, 3'b000, 10'h0, 10'h010, 10'h0, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        vt.push_back(mk(3'b010, 3'b010, 3'b000, 10'h0, 10'h010, 10'h0, 3'b010, 1, 0, 10'h010, 3'b000, 16'h0));
        vt.push_back(mk(3'b010, 3'b010, 3'b000, 10'h0, 10'h011, 10'h0, 3'b010, 1, 0, 10'h011, 3'b010, 16'hA010));
        vt.push_back(mk(3'b010, 3'b010, 3'b000, 10'h0, 10'h012, 10'h0, 3'b010, 1, 0, 10'h012, 3'b010, 16'hA011));
        vt.push_back(mk(3'b010, 3'b000, 3'b000, 10'h0, 10'h013, 10'h0, 3'b010, 1, 0, 10'h013, 3'b010, 16'hA012));
        vt.push_back(mk(3'b000, 3'b000, 3'b000, 10'h0, 10'h000, 10'h0, 3'b000, 0, 0, 10'h000, 3'b010, 16'hA013));
        vt.push_back(mk(3'b000, 3'b000, 3'b000, 10'h0, 10'h000, 10'h0, 3'b000, 0, 0, 10'h000, 3'b000, 16'h0));
        run_vecs("burst4");

        // Requester 2 locked for 12 accesses, requester 0 pending
        k2 = 0;
        done0 = 1'b0;
        for (int c = 0; c < 17; c++) begin
            nxt();
            drive({(k2 < 12), 1'b0, !done0}, {(k2 < 11), 2'b00}, 3'b001,
                  10'h3F0, 10'h000, 10'(32'h040 + k2));
            @(negedge clk);
            chk($sformatf("cap[%0d] gnt", c), 32'(bus.gnt), 32'(t3_exp[c]));
            if (c == 9) chk("cap forced release count", 32'(k2), 32'd8);
            if (bus.gnt[2] && bus.mem_en) k2++;
            if (bus.gnt[0] && bus.mem_en) done0 = 1'b1;
        end
        chk("cap total accesses", 32'(k2), 32'd12);
        chk("cap req0 served", 32'(done0), 32'd1);
        chk("cap ram 3f0", 32'(ram[10'h3F0]), 32'h13F0);

        // Requesters 1 and 2 interleave, then requester 0 joins mid-burst
        for (int c = 0; c < 10; c++) begin
            nxt();
            drive(t4_req[c], t4_lock[c], 3'b000, 10'h080, 10'h060, 10'h070);
            @(negedge clk);
            chk($sformatf("late0[%0d] gnt", c), 32'(bus.gnt), 32'(t4_exp[c]));
        end

        // Reset in the middle of a requester 0 burst
        nxt();
        drive(3'b001, 3'b001, 3'b000, 10'h050, 10'h060, 10'h070);
        @(negedge clk);
        chk("mid c0 gnt", 32'(bus.gnt), 32'h0);
        nxt();
        @(negedge clk);
        chk("mid c1 gnt", 32'(bus.gnt), 32'h1);
        chk("mid c1 mem_en", 32'(bus.mem_en), 32'h1);
        nxt();
        @(negedge clk);
        chk("mid c2 rvalid", 32'(bus.rvalid), 32'h1);
        chk("mid c2 rdata", 32'(bus.rdata), 32'hA050);
        #2 reset = 1'b0;
        #1;
        chk("async gnt", 32'(bus.gnt), 32'h0);
        chk("async rvalid", 32'(bus.rvalid), 32'h0);
        chk("async mem_en", 32'(bus.mem_en), 32'h0);
        chk("async rdata", 32'(bus.rdata), 32'h0);
        drive(3'b111, 3'b001, 3'b000, 10'h050, 10'h060, 10'h070);
        nxt();
        @(negedge clk);
        chk("in rst gnt", 32'(bus.gnt), 32'h0);
        chk("in rst mem_en", 32'(bus.mem_en), 32'h0);
        reset = 1'b1;
        nxt();
        @(negedge clk);
        chk("post rst gnt", 32'(bus.gnt), 32'h1);
        chk("post rst mem_en", 32'(bus.mem_en), 32'h1);

        // Owner drops req while locked: no access, release, next requester
        nxt();
        drive(3'b110, 3'b001, 3'b000, 10'h050, 10'h060, 10'h070);
        @(negedge clk);
        chk("drop gnt held", 32'(bus.gnt), 32'h1);
        chk("drop no access", 32'(bus.mem_en), 32'h0);
        nxt();
        @(negedge clk);
        chk("drop idle gnt", 32'(bus.gnt), 32'h0);
        nxt();
        @(negedge clk);
        chk("drop next gnt", 32'(bus.gnt), 32'h2);
        chk("drop next mem_en", 32'(bus.mem_en), 32'h1);
        chk("drop next addr", 32'(bus.mem_addr), 32'h060);
        nxt();
        drive(3'b000, 3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
